// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative radix-2 divider.
//   DIV_DW        : default operand/result width (MIPS only uses 32)
//   DIV_CNT_W     : default iteration counter width (2**DIV_CNT_W > DIV_DW)
//   DIV_ZERO_QUOT : quotient returned when the divisor is zero
//   div_state_e   : controller states IDLE / BUSY / DONE
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_DW    = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_DW-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
// The dividend register doubles as the quotient register: each step shifts
// the next dividend bit out of the top and the new quotient bit in at the
// bottom, so after DW steps it holds the unsigned quotient.
// Ports:
//   rem       in  DW  current partial remainder
//   dvd       in  DW  dividend/quotient shift register
//   divisor   in  DW  divisor magnitude
//   rem_next  out DW  partial remainder after this step
//   dvd_next  out DW  shift register after this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] dvd,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic [DW-1:0] dvd_next
);

  logic [DW:0] partial;
  logic [DW:0] diff;
  logic        take;

  // The partial value is kept one bit wider than the remainder so that a
  // remainder with its MSB set (divisors above 2**(DW-1)) is not truncated
  // when shifted. Because rem < divisor, partial - divisor always fits in DW
  // bits when it is non-negative, so the top bit of the wide difference is a
  // borrow flag: clear means partial >= divisor and the subtraction is kept.
  always_comb begin
    partial  = {rem, dvd[DW-1]};
    diff     = partial - {1'b0, divisor};
    take     = ~diff[DW];
    rem_next = take ? diff[DW-1:0] : partial[DW-1:0];
    dvd_next = {dvd[DW-2:0], take};
  end

endmodule

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EXE stage.
// One quotient bit is produced per clock; div_end pulses in the cycle that
// begins DW+1 edges after the accepting edge. Results are held until the
// next operation completes.
// Ports:
//   clk            in  1   clock, rising edge
//   resetn         in  1   asynchronous active-low reset
//   div_begin      in  1   request level, accepted while idle
//   div_sign       in  1   1 = signed (DIV), 0 = unsigned (DIVU)
//   div_op1        in  DW  dividend (rs)
//   div_op2        in  DW  divisor (rt)
//   div_cancel     in  1   flush, aborts any operation and blocks acceptance
//   div_result     out DW  quotient (to LO)
//   div_remainder  out DW  remainder (to HI)
//   div_end        out 1   one-cycle pulse, results valid
//   div_busy       out 1   operation in progress
// ---------------------------------------------------------------------------
module iter_divider
  import div_pkg::*;
#(
  parameter int DW    = DIV_DW,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          div_begin,
  input  logic          div_sign,
  input  logic [DW-1:0] div_op1,
  input  logic [DW-1:0] div_op2,
  input  logic          div_cancel,
  output logic [DW-1:0] div_result,
  output logic [DW-1:0] div_remainder,
  output logic          div_end,
  output logic          div_busy
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    rem_q;
  logic [DW-1:0]    dvd_q;
  logic [DW-1:0]    dvs_q;
  logic [DW-1:0]    op1_raw;
  logic             neg_q;
  logic             neg_r;
  logic             dvs_zero;

  logic             op1_neg;
  logic             op2_neg;
  logic [DW-1:0]    op1_mag;
  logic [DW-1:0]    op2_mag;
  logic [DW-1:0]    rem_next;
  logic [DW-1:0]    dvd_next;

  // Sign conditioning of the live operands. Only meaningful on the accept
  // edge; the core always works on unsigned magnitudes. The most negative
  // value negates to itself, which read as unsigned is its true magnitude.
  always_comb begin
    op1_neg = div_sign & div_op1[DW-1];
    op2_neg = div_sign & div_op2[DW-1];
    op1_mag = op1_neg ? -div_op1 : div_op1;
    op2_mag = op2_neg ? -div_op2 : div_op2;
  end

  div_step #(
    .DW (DW)
  ) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .dvd_next (dvd_next)
  );

  // Controller and datapath registers. A flush wins over everything except
  // reset and leaves the visible results untouched. Results and div_end are
  // registered on the edge that leaves DONE, so div_end lands in the first
  // idle cycle, where a still-raised div_begin is immediately accepted again.
  // Divide by zero runs the full iteration and then overrides the results:
  // quotient all-ones, remainder equal to the dividend as presented.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      op1_raw       <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dvs_zero      <= 1'b0;
      div_result    <= '0;
      div_remainder <= '0;
      div_end       <= 1'b0;
      div_busy      <= 1'b0;
    end else if (div_cancel) begin
      state    <= IDLE;
      cnt      <= '0;
      div_end  <= 1'b0;
      div_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_end <= 1'b0;
          if (div_begin) begin
            rem_q    <= '0;
            dvd_q    <= op1_mag;
            dvs_q    <= op2_mag;
            op1_raw  <= div_op1;
            neg_q    <= op1_neg ^ op2_neg;
            neg_r    <= op1_neg;
            dvs_zero <= (div_op2 == '0);
            cnt      <= '0;
            div_busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_next;
          dvd_q <= dvd_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DW - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (dvs_zero) begin
            div_result    <= DIV_ZERO_QUOT;
            div_remainder <= op1_raw;
          end else begin
            div_result    <= neg_q ? -dvd_q : dvd_q;
            div_remainder <= neg_r ? -rem_q : rem_q;
          end
          div_end  <= 1'b1;
          div_busy <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          div_end  <= 1'b0;
          div_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
// Directed test of iter_divider. Each request pushes its hand-computed
// quotient/remainder into a scoreboard queue; an independent monitor pops
// and compares whenever div_end is seen. Timing, cancel, reset and
// back-to-back behaviour are checked from the main sequence.
// ---------------------------------------------------------------------------
module tb_iter_divider;

  typedef struct {
    string       tag;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        div_begin;
  logic        div_sign;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_cancel;
  logic [31:0] div_result;
  logic [31:0] div_remainder;
  logic        div_end;
  logic        div_busy;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;

  iter_divider #(
    .DW    (32),
    .CNT_W (6)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .div_begin     (div_begin),
    .div_sign      (div_sign),
    .div_op1       (div_op1),
    .div_op2       (div_op2),
    .div_cancel    (div_cancel),
    .div_result    (div_result),
    .div_remainder (div_remainder),
    .div_end       (div_end),
    .div_busy      (div_busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence itself gets stuck somewhere.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, report a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sample on the falling edge, well away from the
  // active edge, and compare every div_end against the oldest expectation.
  always @(negedge clk) begin
    if (resetn && div_end) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_div_end", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput({e.tag, "_quot"}, div_result, e.q);
        checkOutput({e.tag, "_rem"}, div_remainder, e.r);
      end
    end
  end

  // Issue one request and return #1 after the accept edge with div_begin
  // dropped and the operand buses scrambled, so late operand changes are
  // exercised on every operation.
  task automatic applyStimulus(input string tag, input bit sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit expect_end,
                               input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    @(negedge clk);
    div_cancel = 1'b0;
    div_sign   = sgn;
    div_op1    = a;
    div_op2    = b;
    div_begin  = 1'b1;
    if (expect_end) begin
      e.tag = tag;
      e.q   = eq;
      e.r   = er;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    div_begin = 1'b0;
    div_sign  = ~sgn;
    div_op1   = 32'hDEAD_BEEF;
    div_op2   = 32'h0000_0001;
    checkOutput({tag, "_accept_busy"}, {31'd0, div_busy}, 32'd1);
  endtask

  // Wait (bounded) for div_end after an accept and check latency and the
  // number of cycles div_busy was high.
  task automatic waitForEnd(input string tag);
    int lat;
    int busy_cycles;
    lat         = 0;
    busy_cycles = 0;
    while (!div_end && lat < 60) begin
      if (div_busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd33);
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
  endtask

  task automatic runOp(input string tag, input bit sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
    applyStimulus(tag, sgn, a, b, 1'b1, eq, er);
    waitForEnd(tag);
  endtask

  initial begin
    int k;
    int end1;
    int end2;
    int unstable;
    exp_t e;

    resetn     = 1'b0;
    div_begin  = 1'b0;
    div_sign   = 1'b0;
    div_op1    = '0;
    div_op2    = '0;
    div_cancel = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_result", div_result, 32'd0);
    checkOutput("reset_remainder", div_remainder, 32'd0);
    checkOutput("reset_end", {31'd0, div_end}, 32'd0);
    checkOutput("reset_busy", {31'd0, div_busy}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    runOp("u100_7",     1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002);
    runOp("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runOp("s_7_m2",     1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001);
    runOp("s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000);
    runOp("u_max_1",    1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFF, 32'h0000_0000);
    runOp("u_div0",     1'b0, 32'h1234_5678,  32'h0000_0000,  32'hFFFF_FFFF, 32'h1234_5678);
    runOp("s_div0",     1'b1, 32'hFFFF_FF00,  32'h0000_0000,  32'hFFFF_FFFF, 32'hFFFF_FF00);
    runOp("u_bigdvs",   1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001, 32'h7FFF_FFFE);
    runOp("s_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'h0000_000E, 32'hFFFF_FFFE);

    // Cancel during BUSY cycle 10: no div_end, idle next edge, results kept.
    applyStimulus("cancel_op", 1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    div_cancel = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("cancel_busy", {31'd0, div_busy}, 32'd0);
    checkOutput("cancel_end", {31'd0, div_end}, 32'd0);
    checkOutput("cancel_hold_result", div_result, 32'h0000_000E);
    checkOutput("cancel_hold_remainder", div_remainder, 32'hFFFF_FFFE);

    // Cancel held while idle must block a pending request.
    @(negedge clk);
    div_sign  = 1'b0;
    div_op1   = 32'd9;
    div_op2   = 32'd3;
    div_begin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("cancel_idle_blocks", {31'd0, div_busy}, 32'd0);

    // Immediate new request after the flush.
    runOp("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Asynchronous reset in BUSY cycle 20, asserted between clock edges.
    applyStimulus("reset_op", 1'b0, 32'd77, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (19) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_result", div_result, 32'd0);
    checkOutput("async_rst_remainder", div_remainder, 32'd0);
    checkOutput("async_rst_end", {31'd0, div_end}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, div_busy}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    runOp("after_reset", 1'b0, 32'd45, 32'd6, 32'd7, 32'd3);

    // Back-to-back: div_begin held across two operations.
    @(negedge clk);
    div_cancel = 1'b0;
    div_sign   = 1'b0;
    div_op1    = 32'd20;
    div_op2    = 32'd6;
    div_begin  = 1'b1;
    e.tag = "b2b_first";
    e.q   = 32'd3;
    e.r   = 32'd2;
    sb_q.push_back(e);
    e.tag = "b2b_second";
    e.q   = 32'd10;
    e.r   = 32'd0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    div_op1  = 32'd50;
    div_op2  = 32'd5;
    k        = 0;
    end1     = -1;
    end2     = -1;
    unstable = 0;
    while (end2 < 0 && k < 150) begin
      if (div_end) begin
        if (end1 < 0) end1 = k;
        else end2 = k;
      end else if (end1 >= 0) begin
        if (div_result !== 32'd3 || div_remainder !== 32'd2) unstable++;
      end
      if (end1 >= 0 && k == end1 + 1) div_begin = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    div_begin = 1'b0;
    checkOutput("b2b_first_latency", 32'(end1), 32'd33);
    checkOutput("b2b_pulse_gap", 32'(end2 - end1), 32'd34);
    checkOutput("b2b_results_stable", 32'(unstable), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
